// File: rtl/lcd_byte_writer_pkg.sv
// Shared definitions for lcd_byte_writer: FSM state encoding, default timing,
// delay-counter sizing and HD44780 command codes.
// Optional macro: LCD_BYTE_WRITER_INIT_EN adds the power-up init states.
package lcd_byte_writer_pkg;

    localparam int unsigned CNT_W = 20;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    localparam int unsigned DEF_SETUP_CYC = 2;
    localparam int unsigned DEF_E_HIGH_CYC = 12;
    localparam int unsigned DEF_GAP_CYC = 50;
    localparam int unsigned DEF_CMD_WAIT_CYC = 2000;
    localparam int unsigned DEF_CLR_WAIT_CYC = 82000;
    localparam int unsigned DEF_PWRUP_CYC = 750000;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP_H,
        ST_STROBE_H,
        ST_GAP,
        ST_SETUP_L,
        ST_STROBE_L,
        ST_WAIT
`ifdef LCD_BYTE_WRITER_INIT_EN
        ,
        ST_INIT_RST,
        ST_INIT_PWR,
        ST_INIT_SETUP,
        ST_INIT_STROBE,
        ST_INIT_WAIT
`endif
    } state_e;

    // Counter load value for an N-cycle state; a zero length still lasts one cycle.
    function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
        logic [CNT_W-1:0] v;
        v = (n == 0) ? '0 : CNT_W'(n - 1);
        return v;
    endfunction

    // Clear and home (0x03 is home with the don't-care bit set) need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == LCD_CMD_CLEAR || b == LCD_CMD_HOME || b == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Byte request handshake plus LCD pin group for lcd_byte_writer.
interface lcd_byte_writer_if;

    logic [7:0] iData;
    logic       iRS;
    logic       iValid;
    logic       oReady;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_D;

    modport master (
        output iData, iRS, iValid,
        input  oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
    );

    modport slave (
        input  iData, iRS, iValid,
        output oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
    );

endinterface

// File: rtl/lcd_byte_writer_delay_counter.sv
// Single down-counter that times every state of lcd_byte_writer.
module lcd_delay_counter
    import lcd_byte_writer_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iLoad,
    input  logic [CNT_W-1:0] iValue,
    output logic             oDone
);

    logic [CNT_W-1:0] count_q, count_d;

    // Load on request, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (iLoad) begin
            count_d = iValue;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign oDone = (count_q == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// 4-bit HD44780-style byte writer: sends a byte as two E-strobed nibbles
// followed by a command-dependent busy wait.
// Optional macro: LCD_BYTE_WRITER_INIT_EN runs the power-up init sequence.
module lcd_byte_writer
    import lcd_byte_writer_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = DEF_SETUP_CYC,
    parameter int unsigned E_HIGH_CYC   = DEF_E_HIGH_CYC,
    parameter int unsigned GAP_CYC      = DEF_GAP_CYC,
    parameter int unsigned CMD_WAIT_CYC = DEF_CMD_WAIT_CYC,
    parameter int unsigned CLR_WAIT_CYC = DEF_CLR_WAIT_CYC,
    parameter int unsigned PWRUP_CYC    = DEF_PWRUP_CYC
)(
    input logic              Clock,
    input logic              Reset,
    lcd_byte_writer_if.slave bus
);

    if (SETUP_CYC > CNT_MAX || E_HIGH_CYC > CNT_MAX || GAP_CYC > CNT_MAX ||
        CMD_WAIT_CYC > CNT_MAX || CLR_WAIT_CYC > CNT_MAX || PWRUP_CYC > CNT_MAX) begin : g_cfg_err
        $error("lcd_byte_writer: timing parameter exceeds 20-bit counter range");
    end

`ifdef LCD_BYTE_WRITER_INIT_EN
    localparam state_e RESET_STATE = ST_INIT_RST;
    logic [1:0] step_q, step_d;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [3:0]       lcd_d_q, lcd_d_d;
    logic             ready_q, ready_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_done;

    lcd_delay_counter u_delay (
        .Clock  (Clock),
        .Reset  (Reset),
        .iLoad  (cnt_load),
        .iValue (cnt_value),
        .oDone  (cnt_done)
    );

    // Next-state and byte capture; every state exits when the counter reaches zero.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rs_d    = rs_q;
`ifdef LCD_BYTE_WRITER_INIT_EN
        step_d  = step_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.iValid && ready_q) begin
                    state_d = ST_SETUP_H;
                    data_d  = bus.iData;
                    rs_d    = bus.iRS;
                end
            end
            ST_SETUP_H:  if (cnt_done) state_d = ST_STROBE_H;
            ST_STROBE_H: if (cnt_done) state_d = ST_GAP;
            ST_GAP:      if (cnt_done) state_d = ST_SETUP_L;
            ST_SETUP_L:  if (cnt_done) state_d = ST_STROBE_L;
            ST_STROBE_L: if (cnt_done) state_d = ST_WAIT;
            ST_WAIT:     if (cnt_done) state_d = ST_IDLE;
`ifdef LCD_BYTE_WRITER_INIT_EN
            ST_INIT_RST:    if (cnt_done) state_d = ST_INIT_PWR;
            ST_INIT_PWR:    if (cnt_done) state_d = ST_INIT_SETUP;
            ST_INIT_SETUP:  if (cnt_done) state_d = ST_INIT_STROBE;
            ST_INIT_STROBE: if (cnt_done) state_d = ST_INIT_WAIT;
            ST_INIT_WAIT: begin
                if (cnt_done) begin
                    if (step_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = ST_INIT_SETUP;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter reload on every state change, and registered pin values for the next state.
    always_comb begin
        cnt_load  = (state_d != state_q);
        cnt_value = '0;
        case (state_d)
            ST_SETUP_H, ST_SETUP_L:   cnt_value = cyc_load(SETUP_CYC);
            ST_STROBE_H, ST_STROBE_L: cnt_value = cyc_load(E_HIGH_CYC);
            ST_GAP:                   cnt_value = cyc_load(GAP_CYC);
            ST_WAIT:                  cnt_value = is_long_cmd(rs_d, data_d) ? cyc_load(CLR_WAIT_CYC)
                                                                            : cyc_load(CMD_WAIT_CYC);
`ifdef LCD_BYTE_WRITER_INIT_EN
            ST_INIT_PWR:    cnt_value = cyc_load(PWRUP_CYC);
            ST_INIT_SETUP:  cnt_value = cyc_load(SETUP_CYC);
            ST_INIT_STROBE: cnt_value = cyc_load(E_HIGH_CYC);
            ST_INIT_WAIT: begin
                case (step_q)
                    2'd0:    cnt_value = cyc_load(PWRUP_CYC * 41 / 150);
                    2'd1:    cnt_value = cyc_load(CMD_WAIT_CYC * 5 / 2);
                    default: cnt_value = cyc_load(CMD_WAIT_CYC);
                endcase
            end
`endif
            default: cnt_value = '0;
        endcase

        // Pins are computed from the state being entered so they line up with it.
        e_d      = (state_d == ST_STROBE_H) || (state_d == ST_STROBE_L);
        lcd_rs_d = lcd_rs_q;
        lcd_d_d  = lcd_d_q;
        ready_d  = (state_d == ST_IDLE);
        case (state_d)
            ST_SETUP_H, ST_STROBE_H, ST_GAP: begin
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[7:4];
            end
            ST_SETUP_L, ST_STROBE_L: begin
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[3:0];
            end
`ifdef LCD_BYTE_WRITER_INIT_EN
            ST_INIT_SETUP, ST_INIT_STROBE: begin
                e_d      = (state_d == ST_INIT_STROBE);
                lcd_rs_d = 1'b0;
                lcd_d_d  = (step_d == 2'd3) ? 4'h2 : 4'h3;
            end
`endif
            default: ;
        endcase
    end

    // State, captured byte and output registers.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= RESET_STATE;
            data_q   <= '0;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
            lcd_rs_q <= 1'b0;
            lcd_d_q  <= '0;
            ready_q  <= 1'b0;
`ifdef LCD_BYTE_WRITER_INIT_EN
            step_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            e_q      <= e_d;
            lcd_rs_q <= lcd_rs_d;
            lcd_d_q  <= lcd_d_d;
            ready_q  <= ready_d;
`ifdef LCD_BYTE_WRITER_INIT_EN
            step_q   <= step_d;
`endif
        end
    end

    assign bus.oReady  = ready_q;
    assign bus.oLCD_E  = e_q;
    assign bus.oLCD_RS = lcd_rs_q;
    assign bus.oLCD_RW = 1'b0;
    assign bus.oLCD_D  = lcd_d_q;

endmodule

// File: doc/lcd_byte_writer.md
LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles that RS/D are stable before E rises.
REQ-002 Parameter E_HIGH_CYC, default 12: cycles that E is high per nibble.
REQ-003 Parameter GAP_CYC, default 50: E-low cycles between the high and low nibble.
REQ-004 Parameter CMD_WAIT_CYC, default 2000: post-byte wait for ordinary bytes.
REQ-005 Parameter CLR_WAIT_CYC, default 82000: post-byte wait for clear/home commands.
REQ-006 Parameter PWRUP_CYC, default 750000: initial power-up wait, used only with LCD_INIT_EN.
REQ-007 Clock  input  1  system clock; all logic is on the rising edge.
REQ-008 Reset  input  1  synchronous, active-low reset.
REQ-009 iData  input  8  byte to write; sourced from the ALU result/LED path.
REQ-010 iRS  input  1  register select: 0 = command, 1 = character data.
REQ-011 iValid  input  1  request to write iData/iRS.
REQ-012 oReady  output  1  block idle; a byte is accepted on Clock when iValid and oReady are both 1.
REQ-013 oLCD_E  output  1  LCD enable strobe.
REQ-014 oLCD_RS  output  1  LCD register select.
REQ-015 oLCD_RW  output  1  LCD read/write; tied to 0 (write only).
REQ-016 oLCD_D  output  4  LCD data nibble (SF_D[11:8]).

Function
REQ-017 The FSM SHALL have these states: IDLE, SETUP_H, STROBE_H, GAP, SETUP_L, STROBE_L, WAIT (plus INIT_* when LCD_INIT_EN is defined).
REQ-018 oReady SHALL be 1 only in IDLE.
REQ-019 On accept, the block SHALL register iData and iRS, and move to SETUP_H on the next cycle.
REQ-020 SETUP_H: oLCD_D = byte[7:4], oLCD_RS = captured RS, E = 0, for SETUP_CYC cycles.
REQ-021 STROBE_H: E = 1 for E_HIGH_CYC cycles; D and RS are unchanged.
REQ-022 GAP: E = 0 for GAP_CYC cycles; D and RS are held, which provides hold time.
REQ-023 SETUP_L and STROBE_L: same as REQ-020 and REQ-021, but with oLCD_D = byte[3:0].
REQ-024 WAIT: E = 0 for CLR_WAIT_CYC if RS = 0 and the byte is 0x01, 0x02 or 0x03; otherwise E = 0 for CMD_WAIT_CYC. The FSM then returns to IDLE.
REQ-025 oReady SHALL be low for exactly 2*(SETUP_CYC+E_HIGH_CYC)+GAP_CYC+wait cycles after the accept edge.
REQ-026 iValid while busy SHALL be ignored; nothing is queued, and the captured byte is unaffected by input changes.
REQ-027 A single delay down-counter SHALL time all states; it is loaded with N-1 on state entry and the state exits at 0. Any parameter value of 0 SHALL be treated as 1.
REQ-028 oLCD_E SHALL be glitch-free and driven directly from a flip-flop.
REQ-029 The counter SHALL be 20 bits wide, and no parameter may exceed 2^20-1.

Reset
REQ-030 While Reset = 0: oLCD_E = 0, oLCD_RS = 0, oLCD_RW = 0, oLCD_D = 0, oReady = 0, counter = 0, and the FSM is in its reset state.
REQ-031 Reset asserted mid-transfer SHALL drop E on the next edge, abandon the byte, and restart cleanly.
REQ-032 Without LCD_INIT_EN, oReady SHALL be 1 on the first edge after Reset is released.

Configuration
REQ-033 With macro LCD_BYTE_WRITER_INIT_EN defined, the block SHALL run an init sequence after reset before entering IDLE:
- wait PWRUP_CYC;
- nibble 0x3 (RS = 0), then wait PWRUP_CYC*41/150;
- 0x3, then wait CMD_WAIT_CYC*5/2;
- 0x3, then wait CMD_WAIT_CYC;
- 0x2, then wait CMD_WAIT_CYC.
Each nibble SHALL use the SETUP/STROBE timing. oReady SHALL stay 0 throughout.
REQ-034 Without the macro, the INIT states and logic SHALL be absent.

Structure
REQ-035 The shared definitions file SHALL hold the state encodings, the default timing constants, and the LCD command codes (CLEAR 0x01, HOME 0x02).
REQ-036 The delay counter SHALL be a separate sub-module, lcd_delay_counter, with ports Clock, Reset, iLoad, iValue[19:0], oDone.

Verification
All scenarios use SETUP_CYC=2, E_HIGH_CYC=3, GAP_CYC=4, CMD_WAIT_CYC=10, CLR_WAIT_CYC=20, PWRUP_CYC=150.
REQ-037 Write 0x48 with RS = 1 -> two E pulses, each 3 cycles; D = 0x4 then 0x8; RS = 1; oReady low for 24 cycles.
REQ-038 Write 0x01 with RS = 0 -> oReady low for 34 cycles. Write 0x01 with RS = 1 -> oReady low for 24 cycles.
REQ-039 Pulse iValid with 0xFF during the busy window of a 0x41 write -> only nibbles 0x4 and 0x1 appear on oLCD_D.
REQ-040 Assert Reset during STROBE_H of 0x55 -> E = 0 on the next edge, all outputs 0, and oReady = 1 one cycle after release.
REQ-041 Back-to-back: hold iValid high with 0x30 then 0x31 -> the second accept occurs on the first cycle oReady = 1, with no lost cycle.
REQ-042 With LCD_BYTE_WRITER_INIT_EN defined -> after a 150-cycle wait, nibbles 0x3, 0x3, 0x3, 0x2 appear with RS = 0 and the specified waits, then oReady = 1.
